// File: rtl/idct_transpose_buffer_if.sv
// Row-in / column-out bus between the row IDCT, the transpose buffer and col_idct.
// The master side drives rows and accepts columns; the slave side is the buffer.
interface idct_transpose_buffer_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] in0, in1, in2, in3, in4, in5, in6, in7;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
   logic             out_valid;
   logic             out_ready;
   logic             blk_last;

   modport master (
      output in0, in1, in2, in3, in4, in5, in6, in7, in_valid, out_ready,
      input  in_ready, y0, y1, y2, y3, y4, y5, y6, y7, out_valid, blk_last
   );

   modport slave (
      input  in0, in1, in2, in3, in4, in5, in6, in7, in_valid, out_ready,
      output in_ready, y0, y1, y2, y3, y4, y5, y6, y7, out_valid, blk_last
   );
endinterface

// File: rtl/idct_transpose_buffer.sv
// Ping-pong 8x8 transpose: rows are written into one bank while the other bank
// is read out column by column, giving one row in and one column out per cycle.
module idct_transpose_buffer #(
   parameter int WIDTH = 32
) (
   input logic                  clk,
   input logic                  reset,
   idct_transpose_buffer_if.slave bus
);

   logic [WIDTH-1:0] mem [2][8][8];
   logic [WIDTH-1:0] row_in  [8];
   logic [WIDTH-1:0] col_out [8];

   logic [1:0] full;
   logic       wb;
   logic       rb;
   logic [2:0] wr;
   logic [2:0] rc;

   logic in_ready_i;
   logic out_valid_i;
   logic wr_acc;
   logic rd_acc;

   assign row_in[0] = bus.in0;
   assign row_in[1] = bus.in1;
   assign row_in[2] = bus.in2;
   assign row_in[3] = bus.in3;
   assign row_in[4] = bus.in4;
   assign row_in[5] = bus.in5;
   assign row_in[6] = bus.in6;
   assign row_in[7] = bus.in7;

   // Write and read never target the same bank: writing needs !full, reading needs full.
   assign in_ready_i  = !full[wb];
   assign out_valid_i = full[rb];
   assign wr_acc      = bus.in_valid && in_ready_i;
   assign rd_acc      = out_valid_i && bus.out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         full <= 2'b00;
         wb   <= 1'b0;
         rb   <= 1'b0;
         wr   <= 3'd0;
         rc   <= 3'd0;
      end else begin
         if (wr_acc) begin
            wr <= wr + 3'd1;
            if (wr == 3'd7) begin
               full[wb] <= 1'b1;
               wb       <= ~wb;
            end
         end
         if (rd_acc) begin
            rc <= rc + 3'd1;
            if (rc == 3'd7) begin
               full[rb] <= 1'b0;
               rb       <= ~rb;
            end
         end
      end
   end

   // Bank contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk) begin
      if (!reset && wr_acc) begin
         for (int c = 0; c < 8; c++) begin
            mem[wb][wr][c] <= row_in[c];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 8; k++) begin
         col_out[k] = '0;
         if (out_valid_i) begin
            col_out[k] = mem[rb][k][rc];
         end
      end
   end

   assign bus.in_ready  = in_ready_i;
   assign bus.out_valid = out_valid_i;
   assign bus.blk_last  = out_valid_i && (rc == 3'd7);

   assign bus.y0 = col_out[0];
   assign bus.y1 = col_out[1];
   assign bus.y2 = col_out[2];
   assign bus.y3 = col_out[3];
   assign bus.y4 = col_out[4];
   assign bus.y5 = col_out[5];
   assign bus.y6 = col_out[6];
   assign bus.y7 = col_out[7];

endmodule

// File: tb/tb_idct_transpose_buffer.sv
// Bench for idct_transpose_buffer: directed and random row streams compared every
// cycle against a block-queue transpose model.
module tb_idct_transpose_buffer;
   localparam int W = 32;
   typedef logic [7:0][7:0][W-1:0] blk_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   idct_transpose_buffer_if #(.WIDTH(W)) bus ();
   idct_transpose_buffer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   // Model: queue of complete blocks awaiting readout; head is read at column col.
   blk_t           q[$];
   blk_t           part;
   int             wrow, col, blk_no;
   logic [W-1:0]   pend [8];
   bit             pend_ok;
   int             mode;
   int             total, bad;
   int             cols_seen, cols_exp;
   bit             prev_stall;
   logic [8*W-1:0] prev_y;

   task automatic chk(input string tag, input logic [8*W-1:0] obs, input logic [8*W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic gen_row();
      for (int c = 0; c < 8; c++) begin
         if (mode != 0) pend[c] = $urandom;
         else           pend[c] = W'(1000 * blk_no + 100 * wrow + c);
      end
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      reset      = 1'b0;
      q.delete();
      wrow       = 0;
      col        = 0;
      blk_no     = 0;
      prev_stall = 0;
      pend_ok    = 0;
   endtask

   task automatic drive_cycle(input logic iv, input logic ordy);
      logic           exp_ov, exp_ir, exp_bl;
      logic [8*W-1:0] exp_y, obs_y;
      blk_t           h;
      if (!pend_ok) begin
         gen_row();
         pend_ok = 1;
      end
      bus.in0 = pend[0]; bus.in1 = pend[1]; bus.in2 = pend[2]; bus.in3 = pend[3];
      bus.in4 = pend[4]; bus.in5 = pend[5]; bus.in6 = pend[6]; bus.in7 = pend[7];
      bus.in_valid  = iv;
      bus.out_ready = ordy;
      @(negedge clk);
      exp_ov = (q.size() > 0);
      exp_ir = (q.size() < 2);
      exp_bl = exp_ov && (col == 7);
      exp_y  = '0;
      if (exp_ov) begin
         h = q[0];
         for (int k = 0; k < 8; k++) exp_y[k*W +: W] = h[k][col];
      end
      obs_y = {bus.y7, bus.y6, bus.y5, bus.y4, bus.y3, bus.y2, bus.y1, bus.y0};
      chk("in_ready",  256'(bus.in_ready),  256'(exp_ir));
      chk("out_valid", 256'(bus.out_valid), 256'(exp_ov));
      chk("blk_last",  256'(bus.blk_last),  256'(exp_bl));
      chk("y",         obs_y,               exp_y);
      if (prev_stall) chk("hold", obs_y, prev_y);
      prev_stall = bus.out_valid && !ordy;
      prev_y     = obs_y;
      if (bus.out_valid && ordy) cols_seen++;
      if (exp_ov && ordy) begin
         cols_exp++;
         col++;
         if (col == 8) begin
            col = 0;
            void'(q.pop_front());
         end
      end
      if (iv && exp_ir) begin
         for (int c = 0; c < 8; c++) part[wrow][c] = pend[c];
         wrow++;
         pend_ok = 0;
         if (wrow == 8) begin
            q.push_back(part);
            wrow = 0;
            blk_no++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0; bad = 0; cols_seen = 0; cols_exp = 0;
      mode = 0;
      bus.in0 = '0; bus.in1 = '0; bus.in2 = '0; bus.in3 = '0;
      bus.in4 = '0; bus.in5 = '0; bus.in6 = '0; bus.in7 = '0;
      do_reset();

      // single block, then drain
      for (int i = 0; i < 8; i++)  drive_cycle(1'b1, 1'b1);
      for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b1);

      // three blocks streamed back to back; row 7 of one block meets column 7 of the previous
      do_reset();
      for (int i = 0; i < 24; i++) drive_cycle(1'b1, 1'b1);
      for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b1);

      // backpressure: both banks fill, 17th row waits for block 0's last column
      do_reset();
      for (int i = 0; i < 20; i++) drive_cycle(1'b1, 1'b0);
      for (int i = 0; i < 12; i++) drive_cycle(1'b1, 1'b1);
      for (int i = 0; i < 30; i++) drive_cycle(1'b0, 1'b1);

      // random gapped handshakes with random data
      mode    = 1;
      pend_ok = 0;
      for (int i = 0; i < 400; i++) drive_cycle(1'($urandom % 2), 1'($urandom % 2));
      for (int i = 0; i < 30; i++)  drive_cycle(1'b0, 1'b1);

      // reset with one full block partly read and a partial block in flight
      mode = 0;
      do_reset();
      for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0);
      do_reset();
      drive_cycle(1'b0, 1'b0);
      for (int i = 0; i < 8; i++)  drive_cycle(1'b1, 1'b0);
      for (int i = 0; i < 12; i++) drive_cycle(1'b0, 1'b1);

      chk("col_count", 256'(cols_seen), 256'(cols_exp));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
